// File: rtl/yarp_lsu.sv
// ---------------------------------------------------------------------------
// yarp_lsu -- load/store unit between the YARP execute stage and the
// external data-memory port.
//
// Takes one load/store command at a time and turns it into a word-aligned
// memory request with byte enables and lane-positioned store data. It then
// runs the req/gnt/rvalid handshake. Load data is extracted from its lane
// and sign- or zero-extended. Completion is a single-cycle lsu_done_o pulse.
//
// Build option:
//   YARP_LSU_MISALIGN_TRAP_EN
//     Defined   : misaligned half-word and word accesses complete
//                 immediately with lsu_err_o and no memory request.
//     Undefined : the offending low address bits are ignored and the access
//                 proceeds. Only the RESERVED size reports an error.
//
// Ports:
//   clk, reset_n       core clock, asynchronous active-low reset
//   lsu_req_i          command valid (sampled only while not busy)
//   lsu_we_i           1 = store, 0 = load
//   lsu_addr_i         byte address
//   lsu_wdata_i        store data, right-justified
//   lsu_size_i         0 byte, 1 half, 2 reserved, 3 word
//   lsu_zero_ext_i     zero-extend load data (LBU/LHU)
//   lsu_busy_o         command in flight
//   lsu_done_o         one-cycle completion pulse
//   lsu_err_o          error, valid with lsu_done_o
//   lsu_rdata_o        extended load data, held until the next load completes
//   mem_req_o          memory request
//   mem_we_o           memory write
//   mem_addr_o         word-aligned memory address
//   mem_be_o           byte enables
//   mem_wdata_o        lane-positioned store data
//   mem_gnt_i          request accepted
//   mem_rvalid_i       read data valid
//   mem_rdata_i        read data
// ---------------------------------------------------------------------------
module yarp_lsu #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [31:0]       lsu_wdata_i,
  input  logic [1:0]        lsu_size_i,
  input  logic              lsu_zero_ext_i,
  output logic              lsu_busy_o,
  output logic              lsu_done_o,
  output logic              lsu_err_o,
  output logic [31:0]       lsu_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_RDWAIT = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_RSVD = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        mem_be_q;
  logic [31:0]       mem_wdata_q;
  logic              err_q;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              zext_q;
  logic [31:0]       rdata_q;

  // Command decode (combinational, consumed only when accepted in IDLE)
  logic [1:0]  cmd_off;
  logic        cmd_err;
  logic [3:0]  cmd_be;
  logic [31:0] cmd_wdata;

  always_comb begin
    cmd_off = lsu_addr_i[1:0];
    cmd_err = (lsu_size_i == SZ_RSVD);
`ifdef YARP_LSU_MISALIGN_TRAP_EN
    if ((lsu_size_i == SZ_HALF) && lsu_addr_i[0])
      cmd_err = 1'b1;
    if ((lsu_size_i == SZ_WORD) && (lsu_addr_i[1:0] != 2'b00))
      cmd_err = 1'b1;
`else
    // Misaligned accesses are silently aligned down inside their word.
    if (lsu_size_i == SZ_HALF)
      cmd_off[0] = 1'b0;
    if (lsu_size_i == SZ_WORD)
      cmd_off = 2'b00;
`endif
    case (lsu_size_i)
      SZ_BYTE: begin
        cmd_be    = 4'b0001 << cmd_off;
        cmd_wdata = {4{lsu_wdata_i[7:0]}};
      end
      SZ_HALF: begin
        cmd_be    = cmd_off[1] ? 4'b1100 : 4'b0011;
        cmd_wdata = {2{lsu_wdata_i[15:0]}};
      end
      SZ_WORD: begin
        cmd_be    = 4'b1111;
        cmd_wdata = lsu_wdata_i;
      end
      default: begin
        cmd_be    = 4'b0000;
        cmd_wdata = 32'h0000_0000;
      end
    endcase
  end

  // Load lane extraction from the offset/size captured at acceptance
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  always_comb begin
    case (off_q)
      2'd0:    ld_byte = mem_rdata_i[7:0];
      2'd1:    ld_byte = mem_rdata_i[15:8];
      2'd2:    ld_byte = mem_rdata_i[23:16];
      default: ld_byte = mem_rdata_i[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (size_q)
      SZ_BYTE: ld_ext = zext_q ? {24'h000000, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_ext = zext_q ? {16'h0000, ld_half}   : {{16{ld_half[15]}}, ld_half};
      default: ld_ext = mem_rdata_i;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (lsu_req_i) state_d = cmd_err ? ST_DONE : ST_REQ;
      ST_REQ:    if (mem_gnt_i) state_d = mem_we_q ? ST_DONE : ST_RDWAIT;
      // rvalid is only honoured here, so one arriving alongside the grant
      // (still in REQ) or after a reset (in IDLE) is dropped.
      ST_RDWAIT: if (mem_rvalid_i) state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0000_0000;
      err_q       <= 1'b0;
      off_q       <= 2'b00;
      size_q      <= SZ_BYTE;
      zext_q      <= 1'b0;
      rdata_q     <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (lsu_req_i) begin
            err_q <= cmd_err;
            // Erroring commands leave the memory port untouched.
            if (!cmd_err) begin
              mem_req_q   <= 1'b1;
              mem_we_q    <= lsu_we_i;
              mem_addr_q  <= {lsu_addr_i[ADDR_W-1:2], 2'b00};
              mem_be_q    <= cmd_be;
              mem_wdata_q <= cmd_wdata;
              off_q       <= cmd_off;
              size_q      <= lsu_size_i;
              zext_q      <= lsu_zero_ext_i;
            end
          end
        end
        ST_REQ: begin
          if (mem_gnt_i)
            mem_req_q <= 1'b0;
        end
        ST_RDWAIT: begin
          if (mem_rvalid_i)
            rdata_q <= ld_ext;
        end
        default: ;
      endcase
    end
  end

  assign lsu_busy_o  = (state_q != ST_IDLE);
  assign lsu_done_o  = (state_q == ST_DONE);
  assign lsu_err_o   = (state_q == ST_DONE) && err_q;
  assign lsu_rdata_o = rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_yarp_lsu.sv
// ---------------------------------------------------------------------------
// tb_yarp_lsu -- directed testbench for yarp_lsu.
// Inputs change just after the falling edge. Outputs are checked on the
// falling edge, so every check sees the state for the current cycle.
// "Cycle 0" is the cycle in which the command is presented.
// ---------------------------------------------------------------------------
module tb_yarp_lsu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        lsu_req_i;
  logic        lsu_we_i;
  logic [31:0] lsu_addr_i;
  logic [31:0] lsu_wdata_i;
  logic [1:0]  lsu_size_i;
  logic        lsu_zero_ext_i;
  logic        lsu_busy_o;
  logic        lsu_done_o;
  logic        lsu_err_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  yarp_lsu #(.ADDR_W(32)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .lsu_req_i     (lsu_req_i),
    .lsu_we_i      (lsu_we_i),
    .lsu_addr_i    (lsu_addr_i),
    .lsu_wdata_i   (lsu_wdata_i),
    .lsu_size_i    (lsu_size_i),
    .lsu_zero_ext_i(lsu_zero_ext_i),
    .lsu_busy_o    (lsu_busy_o),
    .lsu_done_o    (lsu_done_o),
    .lsu_err_o     (lsu_err_o),
    .lsu_rdata_o   (lsu_rdata_o),
    .mem_req_o     (mem_req_o),
    .mem_we_o      (mem_we_o),
    .mem_addr_o    (mem_addr_o),
    .mem_be_o      (mem_be_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_gnt_i     (mem_gnt_i),
    .mem_rvalid_i  (mem_rvalid_i),
    .mem_rdata_i   (mem_rdata_i)
  );

  task automatic drive_cmd(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size,
                           input logic zext);
    lsu_req_i      = 1'b1;
    lsu_we_i       = we;
    lsu_addr_i     = addr;
    lsu_wdata_i    = wdata;
    lsu_size_i     = size;
    lsu_zero_ext_i = zext;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_addr_i = '0; lsu_wdata_i = '0;
    lsu_size_i = 2'd0; lsu_zero_ext_i = 1'b0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mem_req_o, mem_we_o, lsu_busy_o, lsu_done_o, lsu_err_o} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {mem_req_o, mem_we_o, lsu_busy_o, lsu_done_o, lsu_err_o});
    end
    n_checks++;
    if ({mem_addr_o, mem_be_o, mem_wdata_o, lsu_rdata_o} !== 100'h0) begin
      n_fail++;
      $display("FAIL reset_data: addr %h be %b wdata %h rdata %h want all 0",
               mem_addr_o, mem_be_o, mem_wdata_o, lsu_rdata_o);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (lsu_busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy %b req %b want 0 0", lsu_busy_o, mem_req_o);
    end
    $display("reset: released, unit idle");
  endtask

  task automatic test_store_byte;
    drive_cmd(1'b1, 32'h0000_1003, 32'h0000_00AB, 2'd0, 1'b0);
    mem_gnt_i = 1'b1;
    @(negedge clk);  // cycle 1
    lsu_req_i = 1'b0;
    n_checks++;
    if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || lsu_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_c1_ctrl: req %b we %b done %b want 1 1 0", mem_req_o, mem_we_o, lsu_done_o);
    end
    n_checks++;
    if (mem_addr_o !== 32'h0000_1000 || mem_be_o !== 4'b1000 || mem_wdata_o !== 32'hABAB_ABAB) begin
      n_fail++;
      $display("FAIL sb_c1_data: addr %h be %b wdata %h want 00001000 1000 abababab",
               mem_addr_o, mem_be_o, mem_wdata_o);
    end
    @(negedge clk);  // cycle 2
    mem_gnt_i = 1'b0;
    n_checks++;
    if (lsu_done_o !== 1'b1 || lsu_err_o !== 1'b0 || mem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_c2_done: done %b err %b req %b want 1 0 0", lsu_done_o, lsu_err_o, mem_req_o);
    end
    @(negedge clk);  // cycle 3
    n_checks++;
    if (lsu_done_o !== 1'b0 || lsu_busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_c3_idle: done %b busy %b want 0 0", lsu_done_o, lsu_busy_o);
    end
    $display("store byte addr=00001003 wdata=000000ab complete");
  endtask

  // Single-cycle-grant load followed by rvalid one cycle later; done at cycle 3.
  task automatic run_load(input string nm, input logic [31:0] addr, input logic [1:0] size,
                          input logic zext, input logic [31:0] rdata,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_data);
    drive_cmd(1'b0, addr, 32'h0, size, zext);
    mem_gnt_i = 1'b1;
    @(negedge clk);  // cycle 1
    lsu_req_i = 1'b0;
    n_checks++;
    if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== exp_addr || mem_be_o !== exp_be) begin
      n_fail++;
      $display("FAIL %s_req: req %b we %b addr %h be %b want 1 0 %h %b",
               nm, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, exp_addr, exp_be);
    end
    @(negedge clk);  // cycle 2
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = rdata;
    n_checks++;
    if (mem_req_o !== 1'b0 || lsu_done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_wait: req %b done %b want 0 0", nm, mem_req_o, lsu_done_o);
    end
    @(negedge clk);  // cycle 3
    mem_rvalid_i = 1'b0;
    n_checks++;
    if (lsu_done_o !== 1'b1 || lsu_err_o !== 1'b0 || lsu_rdata_o !== exp_data) begin
      n_fail++;
      $display("FAIL %s_done: done %b err %b rdata %h want 1 0 %h",
               nm, lsu_done_o, lsu_err_o, lsu_rdata_o, exp_data);
    end
    @(negedge clk);
    $display("load %s addr=%h rdata=%h -> %h", nm, addr, rdata, lsu_rdata_o);
  endtask

  task automatic test_load_half;
    run_load("lh",  32'h0000_2002, 2'd1, 1'b0, 32'h8001_1234, 32'h0000_2000, 4'b1100, 32'hFFFF_8001);
    run_load("lhu", 32'h0000_2002, 2'd1, 1'b1, 32'h8001_1234, 32'h0000_2000, 4'b1100, 32'h0000_8001);
  endtask

  task automatic test_load_byte;
    run_load("lb",  32'h0000_0041, 2'd0, 1'b0, 32'h0000_8500, 32'h0000_0040, 4'b0010, 32'hFFFF_FF85);
    run_load("lbu", 32'h0000_0041, 2'd0, 1'b1, 32'h0000_8500, 32'h0000_0040, 4'b0010, 32'h0000_0085);
  endtask

  // Grant in cycle 4, rvalid in cycle 6, done exactly in cycle 7.
  task automatic test_load_stall;
    drive_cmd(1'b0, 32'h0000_3004, 32'h0, 2'd3, 1'b0);
    mem_gnt_i = 1'b0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      lsu_req_i    = 1'b0;
      mem_gnt_i    = (cyc == 4);
      mem_rvalid_i = (cyc == 6);
      mem_rdata_i  = (cyc == 6) ? 32'hCAFE_F00D : 32'h1111_1111;
      n_checks++;
      if (lsu_done_o !== (cyc == 7)) begin
        n_fail++;
        $display("FAIL lw_stall_done c%0d: done %b want %b", cyc, lsu_done_o, (cyc == 7));
      end
      if (cyc <= 4) begin
        n_checks++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_3004 || mem_be_o !== 4'b1111 || mem_we_o !== 1'b0) begin
          n_fail++;
          $display("FAIL lw_stall_hold c%0d: req %b addr %h be %b we %b want 1 00003004 1111 0",
                   cyc, mem_req_o, mem_addr_o, mem_be_o, mem_we_o);
        end
      end else if (cyc <= 6) begin
        n_checks++;
        if (mem_req_o !== 1'b0) begin
          n_fail++;
          $display("FAIL lw_stall_drop c%0d: req %b want 0", cyc, mem_req_o);
        end
      end
    end
    n_checks++;
    if (lsu_rdata_o !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL lw_stall_data: rdata %h want cafef00d", lsu_rdata_o);
    end
    $display("load word stalled addr=00003004 rdata=%h", lsu_rdata_o);
  endtask

  task automatic test_reserved;
    drive_cmd(1'b1, 32'h0000_6000, 32'h1234_5678, 2'd2, 1'b0);
    @(negedge clk);  // cycle 1
    lsu_req_i = 1'b0;
    n_checks++;
    if (lsu_done_o !== 1'b1 || lsu_err_o !== 1'b1 || mem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rsvd_done: done %b err %b req %b want 1 1 0", lsu_done_o, lsu_err_o, mem_req_o);
    end
    n_checks++;
    if (lsu_rdata_o !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL rsvd_rdata: rdata %h want cafef00d", lsu_rdata_o);
    end
    @(negedge clk);  // cycle 2
    n_checks++;
    if (lsu_done_o !== 1'b0 || lsu_err_o !== 1'b0 || lsu_busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rsvd_after: done %b err %b busy %b req %b want 0 0 0 0",
               lsu_done_o, lsu_err_o, lsu_busy_o, mem_req_o);
    end
    $display("store reserved size addr=00006000 -> error");
  endtask

  task automatic test_misalign;
`ifdef YARP_LSU_MISALIGN_TRAP_EN
    drive_cmd(1'b0, 32'h0000_3001, 32'h0, 2'd3, 1'b0);
    @(negedge clk);
    lsu_req_i = 1'b0;
    n_checks++;
    if (lsu_done_o !== 1'b1 || lsu_err_o !== 1'b1 || mem_req_o !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_trap: done %b err %b req %b want 1 1 0", lsu_done_o, lsu_err_o, mem_req_o);
    end
    @(negedge clk);
    n_checks++;
    if (mem_req_o !== 1'b0 || lsu_busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign_noreq: req %b busy %b want 0 0", mem_req_o, lsu_busy_o);
    end
    $display("load word misaligned addr=00003001 -> trapped");
`else
    run_load("lw_mis", 32'h0000_3001, 2'd3, 1'b0, 32'h0102_0304, 32'h0000_3000, 4'b1111, 32'h0102_0304);
`endif
  endtask

  // Command held high through the whole first transaction: the second one is
  // taken in the IDLE cycle after DONE (cycle 3) and requested in cycle 4.
  task automatic test_back_to_back;
    drive_cmd(1'b1, 32'h0000_0012, 32'h1234_BEEF, 2'd1, 1'b0);
    mem_gnt_i = 1'b1;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      if (cyc == 2) drive_cmd(1'b1, 32'h0000_0021, 32'h0000_005A, 2'd0, 1'b0);
      if (cyc == 4) lsu_req_i = 1'b0;
      n_checks++;
      if (lsu_done_o !== (cyc == 2 || cyc == 5) || mem_req_o !== (cyc == 1 || cyc == 4)) begin
        n_fail++;
        $display("FAIL b2b_ctrl c%0d: done %b req %b want %b %b", cyc, lsu_done_o, mem_req_o,
                 (cyc == 2 || cyc == 5), (cyc == 1 || cyc == 4));
      end
      if (cyc == 1) begin
        n_checks++;
        if (mem_addr_o !== 32'h0000_0010 || mem_be_o !== 4'b1100 || mem_wdata_o !== 32'hBEEF_BEEF) begin
          n_fail++;
          $display("FAIL b2b_sh: addr %h be %b wdata %h want 00000010 1100 beefbeef",
                   mem_addr_o, mem_be_o, mem_wdata_o);
        end
      end
      if (cyc == 3) begin
        n_checks++;
        if (lsu_busy_o !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_bubble: busy %b want 0", lsu_busy_o);
        end
      end
      if (cyc == 4) begin
        n_checks++;
        if (mem_addr_o !== 32'h0000_0020 || mem_be_o !== 4'b0010 || mem_wdata_o !== 32'h5A5A_5A5A) begin
          n_fail++;
          $display("FAIL b2b_sb: addr %h be %b wdata %h want 00000020 0010 5a5a5a5a",
                   mem_addr_o, mem_be_o, mem_wdata_o);
        end
      end
    end
    mem_gnt_i = 1'b0;
    @(negedge clk);
    $display("back-to-back store half 00000012 / store byte 00000021 complete");
  endtask

  task automatic test_reset_mid_req;
    drive_cmd(1'b0, 32'h0000_4000, 32'h0, 2'd3, 1'b0);
    mem_gnt_i = 1'b0;
    @(negedge clk);  // cycle 1, in REQ
    lsu_req_i = 1'b0;
    n_checks++;
    if (mem_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_pre: req %b want 1", mem_req_o);
    end
    #2 reset_n = 1'b0;
    #1;  // still 2 time units before the next rising edge
    n_checks++;
    if (mem_req_o !== 1'b0 || lsu_busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async: req %b busy %b want 0 0", mem_req_o, lsu_busy_o);
    end
    @(negedge clk);
    reset_n = 1'b1;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 32'hDEAD_BEEF;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (lsu_done_o !== 1'b0 || lsu_busy_o !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_stray c%0d: done %b busy %b want 0 0", cyc, lsu_done_o, lsu_busy_o);
      end
    end
    mem_rvalid_i = 1'b0;
    drive_cmd(1'b1, 32'h0000_5000, 32'h7654_3210, 2'd3, 1'b0);
    mem_gnt_i = 1'b1;
    @(negedge clk);  // cycle 1
    lsu_req_i = 1'b0;
    n_checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h0000_5000 || mem_wdata_o !== 32'h7654_3210) begin
      n_fail++;
      $display("FAIL rst_mid_next_req: req %b addr %h wdata %h want 1 00005000 76543210",
               mem_req_o, mem_addr_o, mem_wdata_o);
    end
    @(negedge clk);  // cycle 2
    mem_gnt_i = 1'b0;
    n_checks++;
    if (lsu_done_o !== 1'b1 || lsu_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_next_done: done %b err %b want 1 0", lsu_done_o, lsu_err_o);
    end
    @(negedge clk);
    $display("reset during REQ recovered, store word 00005000 complete");
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_half();
    test_load_byte();
    test_load_stall();
    test_reserved();
    test_misalign();
    test_back_to_back();
    test_reset_mid_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
